// File: rtl/gen_scheduler.sv
// Shares the buffer write port between the fibonacci and timer generators.
// Define GEN_SCHED_TAG_EN to replace the data MSB with the source tag.
module gen_scheduler #(
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop_f_t,
  input  logic              f_valid,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] f_out,
  input  logic [DATA_W-1:0] t_out,
  input  logic              buffer_full,
  input  logic              buffer_empty,
  input  logic              data_2_valid,
  output logic              f_en,
  output logic              t_en,
  output logic              data_1_en,
  output logic [DATA_W-1:0] data_1,
  output logic              src,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       word_cnt
);

  // state  | meaning
  // IDLE   | no source active, waiting for a start
  // ISSUE  | request pulse to the selected generator
  // WAIT   | waiting for the selected x_valid, bounded by WAIT_MAX
  // WRITE  | buffer write strobe with the captured word
  // HOLD   | sources active but buffer full
  // DRAIN  | stopped, waiting for the consumer side to empty
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_HOLD, S_DRAIN
  } state_e;

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_e              state_q, state_d;
  logic                f_act_q, f_act_d, t_act_q, t_act_d;
  logic                last_src_q, last_src_d;
  logic                src_q, src_d;
  logic                f_en_q, f_en_d, t_en_q, t_en_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                terr_q, terr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                live_f, live_t, live_any, go_next, sel;
  logic [DATA_W-1:0]   cap;

  // A stop in the current cycle already counts as "no source active".
  assign live_f   = f_act_q & ~stop_f_t;
  assign live_t   = t_act_q & ~stop_f_t;
  assign live_any = live_f | live_t;
  assign cap      = src_q ? t_out : f_out;

  always_comb begin
    state_d    = state_q;
    f_act_d    = f_act_q;
    t_act_d    = t_act_q;
    last_src_d = last_src_q;
    src_d      = src_q;
    f_en_d     = 1'b0;
    t_en_d     = 1'b0;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    terr_d     = terr_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    go_next    = 1'b0;
    sel        = 1'b0;

    if (stop_f_t) begin
      f_act_d = 1'b0;
      t_act_d = 1'b0;
    end else if (state_q != S_DRAIN) begin
      f_act_d = f_act_q | start_f;
      t_act_d = t_act_q | start_t;
    end

    case (state_q)
      S_IDLE: begin
        if (live_any) state_d = buffer_full ? S_HOLD : S_ISSUE;
      end
      S_ISSUE: begin
        wait_d  = WAIT_W'(WAIT_MAX - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (src_q ? t_valid : f_valid) begin
`ifdef GEN_SCHED_TAG_EN
          data_d = {src_q, cap[DATA_W-2:0]};
`else
          data_d = cap;
`endif
          state_d = S_WRITE;
        end else if (wait_q == '0) begin
          terr_d     = 1'b1;
          last_src_d = src_q;
          go_next    = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_WRITE: begin
        cnt_d      = cnt_q + 16'd1;
        last_src_d = src_q;
        go_next    = 1'b1;
      end
      S_HOLD: begin
        if (!live_any)         state_d = S_DRAIN;
        else if (!buffer_full) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (buffer_empty && !data_2_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_next) begin
      if (!live_any)        state_d = S_DRAIN;
      else if (buffer_full) state_d = S_HOLD;
      else                  state_d = S_ISSUE;
    end

    // Uses last_src_d so a grant decided while leaving WRITE sees the word just served.
    sel = (live_f && live_t) ? ~last_src_d : live_t;
    if (state_d == S_ISSUE) begin
      f_en_d = ~sel;
      t_en_d = sel;
      src_d  = sel;
    end

    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      f_act_q    <= 1'b0;
      t_act_q    <= 1'b0;
      last_src_q <= 1'b1;
      src_q      <= 1'b0;
      f_en_q     <= 1'b0;
      t_en_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= 16'd0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      f_act_q    <= f_act_d;
      t_act_q    <= t_act_d;
      last_src_q <= last_src_d;
      src_q      <= src_d;
      f_en_q     <= f_en_d;
      t_en_q     <= t_en_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
    end
  end

  assign f_en        = f_en_q;
  assign t_en        = t_en_q;
  assign data_1_en   = wr_en_q;
  assign data_1      = data_q;
  assign src         = src_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Randomized bench for gen_scheduler against an event-level reference model.
// Honours GEN_SCHED_TAG_EN the same way as the design.
module tb_gen_scheduler;
  localparam int DW = 16;
  localparam int WM = 4;
  localparam int P_IDLE = 0, P_FLIGHT = 1, P_HOLD = 2, P_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_f, start_t, stop_f_t, f_valid, t_valid;
  logic [DW-1:0] f_out, t_out;
  logic buffer_full, buffer_empty, data_2_valid;
  logic f_en, t_en, data_1_en, src, busy, timeout_err;
  logic [DW-1:0] data_1;
  logic [15:0] word_cnt;

  gen_scheduler #(.DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop_f_t(stop_f_t),
    .f_valid(f_valid), .t_valid(t_valid), .f_out(f_out), .t_out(t_out),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .f_en(f_en), .t_en(t_en), .data_1_en(data_1_en), .data_1(data_1), .src(src),
    .busy(busy), .timeout_err(timeout_err), .word_cnt(word_cnt)
  );

  int checks = 0, failures = 0, cyc = 0;

  // Reference model: phase of the scheduler plus the cycles at which events are due.
  int ph;
  bit m_f, m_t, m_last, m_terr, m_src;
  logic [15:0] m_cnt, m_d1;
  int iss_c, resp_c, wr_c, to_c;
  bit iss_sel, resp_sel, no_drop = 1'b0;

  bit req_sf, req_st, req_stop, req_full, req_empty, req_d2v, req_rst;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_f = 0; m_t = 0; m_last = 1; m_terr = 0; m_src = 0;
    m_cnt = 16'd0; m_d1 = 16'd0;
    iss_c = -1; resp_c = -1; wr_c = -1; to_c = -1;
  endtask

  task automatic sched_issue(input bit lf, input bit lt);
    iss_c   = cyc + 1;
    iss_sel = (lf && lt) ? !m_last : lt;
    m_src   = iss_sel;
    ph      = P_FLIGHT;
  endtask

  task automatic decide_next(input bit lf, input bit lt);
    if (!(lf || lt))   ph = P_DRAIN;
    else if (req_full) ph = P_HOLD;
    else               sched_issue(lf, lt);
  endtask

  task automatic step();
    logic [15:0] fo, tvd, cap;
    bit fv, tv, lf, lt;
    int ph_old, r;
    @(negedge clk);
    cyc++;
    check_val("f_en", f_en, iss_c == cyc && !iss_sel);
    check_val("t_en", t_en, iss_c == cyc && iss_sel);
    check_val("src", src, m_src);
    check_val("data_1_en", data_1_en, wr_c == cyc);
    check_val("data_1", data_1, m_d1);
    check_val("busy", busy, ph != P_IDLE);
    check_val("timeout_err", timeout_err, m_terr);
    check_val("word_cnt", word_cnt, m_cnt);

    // Generator behaviour: respond after 1..3 cycles, on the last wait cycle, or never.
    if (iss_c == cyc) begin
      resp_sel = iss_sel;
      if (!no_drop && $urandom_range(0, 7) == 0) begin
        to_c = cyc + WM; resp_c = -1; wr_c = -1;
      end else begin
        r = $urandom_range(0, 9);
        resp_c = cyc + ((r == 9) ? WM : 1 + (r % 3));
        wr_c = resp_c + 1;
      end
    end
    fo = 16'($urandom); tvd = 16'($urandom); fv = 0; tv = 0;
    if (resp_c == cyc) begin
      if (resp_sel) tv = 1; else fv = 1;
    end else if (ph == P_FLIGHT && $urandom_range(0, 4) == 0) begin
      if (resp_sel) fv = 1; else tv = 1;
    end
    cap = resp_sel ? tvd : fo;

    f_valid = fv; t_valid = tv; f_out = fo; t_out = tvd;
    start_f = req_sf; start_t = req_st; stop_f_t = req_stop;
    buffer_full = req_full; buffer_empty = req_empty; data_2_valid = req_d2v;
    rst = req_rst;

    if (req_rst) model_reset();
    else begin
      if (resp_c == cyc && ph == P_FLIGHT) begin
`ifdef GEN_SCHED_TAG_EN
        m_d1 = {resp_sel, cap[14:0]};
`else
        m_d1 = cap;
`endif
      end
      lf = m_f && !req_stop;
      lt = m_t && !req_stop;
      ph_old = ph;
      case (ph_old)
        P_IDLE: if (lf || lt) begin
          if (req_full) ph = P_HOLD; else sched_issue(lf, lt);
        end
        P_FLIGHT: begin
          if (wr_c == cyc) begin
            m_cnt = m_cnt + 16'd1; m_last = resp_sel; wr_c = -1; decide_next(lf, lt);
          end else if (to_c == cyc) begin
            m_terr = 1; m_last = resp_sel; to_c = -1; decide_next(lf, lt);
          end
        end
        P_HOLD: begin
          if (!(lf || lt)) ph = P_DRAIN;
          else if (!req_full) sched_issue(lf, lt);
        end
        default: if (req_empty && !req_d2v) ph = P_IDLE;
      endcase
      if (req_stop) begin m_f = 0; m_t = 0; end
      else if (ph_old != P_DRAIN) begin m_f = m_f | req_sf; m_t = m_t | req_st; end
    end
  endtask

  task automatic drive_policy(input bit allow_start, input bit allow_stop);
    logic [1:0] p;
    req_sf = 0; req_st = 0; req_stop = 0;
    if (allow_start) begin
      if (ph == P_IDLE) begin
        if ($urandom_range(0, 3) == 0) begin
          p = 2'($urandom_range(1, 3)); req_sf = p[0]; req_st = p[1];
        end
      end else if ($urandom_range(0, 59) == 0) begin
        req_sf = 1'($urandom_range(0, 1)); req_st = !req_sf;
      end
    end
    if (allow_stop && ph != P_IDLE && $urandom_range(0, 24) == 0) req_stop = 1;
    if (req_full) req_full = ($urandom_range(0, 3) != 0);
    else          req_full = ($urandom_range(0, 11) == 0);
    req_empty = ($urandom_range(0, 2) != 0);
    req_d2v   = ($urandom_range(0, 3) == 0);
  endtask

  task automatic go_idle();
    int n = 0;
    while (!(ph == P_IDLE && !m_f && !m_t) && n < 300) begin
      req_sf = 0; req_st = 0; req_stop = 1; req_full = 0; req_empty = 1; req_d2v = 0;
      step();
      n++;
    end
    req_stop = 0;
    step();
    check_val("idle_reached", busy, 0);
  endtask

  initial begin
    int n;
    model_reset();
    rst = 1; start_f = 0; start_t = 0; stop_f_t = 0; f_valid = 0; t_valid = 0;
    f_out = '0; t_out = '0; buffer_full = 0; buffer_empty = 1; data_2_valid = 0;
    req_sf = 0; req_st = 0; req_stop = 0; req_full = 0; req_empty = 1; req_d2v = 0;
    req_rst = 1;
    repeat (3) step();
    req_rst = 0;

    for (int i = 0; i < 2500; i++) begin
      drive_policy(1'b1, 1'b1);
      step();
    end

    // Counter wrap: preload near the top and write a few words.
    go_idle();
    force dut.cnt_q = 16'hFFFD;
    m_cnt = 16'hFFFD;
    step();
    release dut.cnt_q;
    no_drop = 1;
    req_sf = 1; req_st = 1; req_full = 0;
    step();
    for (int i = 0; i < 80; i++) begin
      drive_policy(1'b0, 1'b0);
      step();
    end
    check_val("wrap_seen", word_cnt < 16'hFFFD, 1);

    // Reset during WRITE with the counter at 0xFFFF, then a late valid.
    go_idle();
    force dut.cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.cnt_q;
    req_sf = 1; req_full = 0; req_empty = 1; req_d2v = 0;
    step();
    req_sf = 0;
    n = 0;
    while (wr_c != cyc + 1 && n < 40) begin
      step();
      n++;
    end
    check_val("reach_write", wr_c == cyc + 1, 1);
    req_rst = 1;
    step();
    req_rst = 0;
    resp_c = cyc + 1;
    resp_sel = 0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
